spi_reg_bridge: RTL and testbench



---
 rtl/spi_bridge_pkg.sv | 16 +
 rtl/spi_reg_bridge_if.sv | 23 ++
 rtl/cs_gap_timer.sv | 30 +++
 rtl/spi_reg_bridge.sv | 107 ++++++++++
 tb/tb_spi_reg_bridge.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI byte-stream to register-bus bridge.
// Imported by the bridge top and its testbench.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        RD_REQ,
        RD_WAIT,
        LOAD
    } state_t;

    localparam int         CMD_RW_BIT = 7;
    localparam logic [7:0] REPLY_FILL = 8'h00;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register-bus bundle between the SPI bridge (master) and the register file.
// Read data is valid the cycle after reg_re.
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 7
);

    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    modport master (
        output reg_addr, reg_wdata, reg_we, reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_we, reg_re,
        output reg_rdata
    );

endinterface

// File: rtl/cs_gap_timer.sv
// Counts cs-high cycles while a burst is open; pulses timeout to close it.
// The counter clears on any cs-low cycle and returns to zero on timeout.
module cs_gap_timer #(
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs,
    input  logic in_txn,
    output logic timeout
);

    localparam int            CW   = $clog2(GAP_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(GAP_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    assign timeout = cs && in_txn && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!cs || timeout) begin
            cnt <= '0;
        end else if (in_txn) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Turns SPI slave bytes (command + auto-incrementing burst) into register
// bus reads/writes and queues one reply byte per received byte.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic [7:0] spi_rx,
    output logic [7:0] spi_tx,
    output logic       spi_tx_load,
    output logic       busy,
    output logic       err_late,
    spi_reg_bridge_if.master rbus
);

    state_t            state;
    logic              cs_d;
    logic              in_txn;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic              timeout;
    logic              cs_rise;

    assign cs_rise = !cs_d && cs;
    assign busy    = in_txn;

    cs_gap_timer #(
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) u_gap (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs     (cs),
        .in_txn (in_txn),
        .timeout(timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cs_d           <= 1'b1;
            in_txn         <= 1'b0;
            rw             <= 1'b0;
            addr           <= '0;
            spi_tx         <= 8'h00;
            spi_tx_load    <= 1'b0;
            err_late       <= 1'b0;
            rbus.reg_addr  <= '0;
            rbus.reg_wdata <= 8'h00;
            rbus.reg_we    <= 1'b0;
            rbus.reg_re    <= 1'b0;
        end else begin
            cs_d        <= cs;
            spi_tx_load <= 1'b0;
            err_late    <= 1'b0;
            rbus.reg_we <= 1'b0;
            rbus.reg_re <= 1'b0;
            if (timeout) in_txn <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (cs_rise) state <= CAPTURE;
                end
                CAPTURE: begin
                    if (!in_txn) begin
                        rw     <= spi_rx[CMD_RW_BIT];
                        addr   <= spi_rx[ADDR_W-1:0];
                        in_txn <= 1'b1;
                        state  <= spi_rx[CMD_RW_BIT] ? LOAD : RD_REQ;
                    end else if (rw) begin
                        rbus.reg_we    <= 1'b1;
                        rbus.reg_addr  <= addr;
                        rbus.reg_wdata <= spi_rx;
                        addr           <= addr + 1'b1;
                        state          <= LOAD;
                    end else begin
                        // Dummy byte of a read burst: prefetch the next reg.
                        addr  <= addr + 1'b1;
                        state <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    rbus.reg_re   <= 1'b1;
                    rbus.reg_addr <= addr;
                    state         <= RD_WAIT;
                end
                RD_WAIT: begin
                    state <= LOAD;
                end
                LOAD: begin
                    if (cs) begin
                        spi_tx_load <= 1'b1;
                        spi_tx      <= rw ? REPLY_FILL : rbus.reg_rdata;
                    end else begin
                        err_late <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge with a behavioural register file.
// Logs bus/reply events on the falling edge and compares to hand values.
module tb_spi_reg_bridge;

    localparam int ADDR_W = 7;
    localparam int GAP    = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic [7:0] spi_rx;
    logic [7:0] spi_tx;
    logic       spi_tx_load;
    logic       busy;
    logic       err_late;

    spi_reg_bridge_if #(.ADDR_W(ADDR_W)) rbus ();

    spi_reg_bridge #(
        .ADDR_W     (ADDR_W),
        .GAP_TIMEOUT(GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .spi_rx     (spi_rx),
        .spi_tx     (spi_tx),
        .spi_tx_load(spi_tx_load),
        .busy       (busy),
        .err_late   (err_late),
        .rbus       (rbus)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int rise_cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int n_err    = 0;
    int n_ovl    = 0;

    logic [14:0] we_q[$];
    logic [6:0]  re_q[$];
    logic [7:0]  ld_q[$];
    int          lat_q[$];

    logic [7:0] mem [128];

    function automatic logic [7:0] init_val(input int i);
        if (i == 16) return 8'hAB;
        if (i == 17) return 8'hCD;
        return 8'(i) ^ 8'h5A;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
            rbus.reg_rdata <= 8'h00;
        end else begin
            if (rbus.reg_we) mem[rbus.reg_addr] <= rbus.reg_wdata;
            if (rbus.reg_re) rbus.reg_rdata <= mem[rbus.reg_addr];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rbus.reg_we) we_q.push_back({rbus.reg_addr, rbus.reg_wdata});
            if (rbus.reg_re) re_q.push_back(rbus.reg_addr);
            if (spi_tx_load) begin
                ld_q.push_back(spi_tx);
                lat_q.push_back(cyc - rise_cyc);
            end
            if (err_late) n_err++;
            if (int'(rbus.reg_we) + int'(rbus.reg_re) + int'(spi_tx_load) > 1)
                n_ovl++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        we_q.delete();
        re_q.delete();
        ld_q.delete();
        lat_q.delete();
        n_err = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        cs     = 1'b0;
        spi_rx = b;
        repeat (3) @(negedge clk);
        cs       = 1'b1;
        rise_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        cs     = 1'b1;
        spi_rx = 8'h00;
        hold(3);
        check("rst_tx", spi_tx, 8'h00);
        check("rst_load", spi_tx_load, 0);
        check("rst_we", rbus.reg_we, 0);
        check("rst_re", rbus.reg_re, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_late, 0);
        check("rst_addr", rbus.reg_addr, 0);
        check("rst_wdata", rbus.reg_wdata, 0);
        rst_n = 1'b1;
        hold(5);
        check("idle_load", ld_q.size(), 0);

        // write burst at 5
        clear_logs();
        send_byte(8'h85, 8);
        send_byte(8'h3C, 8);
        send_byte(8'h4D, 8);
        check("wr_n", we_q.size(), 2);
        check("wr0", we_q[0], {7'h05, 8'h3C});
        check("wr1", we_q[1], {7'h06, 8'h4D});
        check("wr_ld_n", ld_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wr_ld%0d", i), ld_q[i], 8'h00);
            check($sformatf("wr_lat%0d", i), lat_q[i], 3);
        end
        check("wr_re_n", re_q.size(), 0);
        check("wr_busy", busy, 1);

        // gap timeout boundary
        hold(GAP - 40);
        check("gap_busy", busy, 1);
        hold(50);
        check("gap_idle", busy, 0);

        clear_logs();
        send_byte(8'h02, 8);
        check("cmd_re_n", re_q.size(), 1);
        check("cmd_re", re_q[0], 7'h02);
        check("cmd_ld", ld_q[0], 8'h58);
        check("cmd_lat", lat_q[0], 5);
        check("cmd_we_n", we_q.size(), 0);
        hold(GAP + 10);

        // read burst at 0x10
        clear_logs();
        send_byte(8'h10, 8);
        send_byte(8'h00, 8);
        send_byte(8'h00, 8);
        check("rd_re_n", re_q.size(), 3);
        check("rd_re0", re_q[0], 7'h10);
        check("rd_re1", re_q[1], 7'h11);
        check("rd_re2", re_q[2], 7'h12);
        check("rd_ld_n", ld_q.size(), 3);
        check("rd_ld0", ld_q[0], 8'hAB);
        check("rd_ld1", ld_q[1], 8'hCD);
        check("rd_ld2", ld_q[2], 8'h48);
        check("rd_lat", lat_q[1], 5);
        check("rd_we_n", we_q.size(), 0);
        hold(GAP + 10);

        // write burst wrapping 7F -> 00
        clear_logs();
        send_byte(8'hFF, 8);
        send_byte(8'h11, 8);
        send_byte(8'h22, 8);
        check("wrap_n", we_q.size(), 2);
        check("wrap0", we_q[0], {7'h7F, 8'h11});
        check("wrap1", we_q[1], {7'h00, 8'h22});
        hold(GAP + 10);

        // read reply misses its load window
        clear_logs();
        @(negedge clk);
        cs     = 1'b0;
        spi_rx = 8'h03;
        hold(3);
        cs       = 1'b1;
        rise_cyc = cyc;
        hold(3);
        cs     = 1'b0;
        spi_rx = 8'h00;
        hold(4);
        check("late_err", n_err, 1);
        check("late_ld_n", ld_q.size(), 0);
        cs       = 1'b1;
        rise_cyc = cyc;
        hold(8);
        check("late_re_n", re_q.size(), 2);
        check("late_re0", re_q[0], 7'h03);
        check("late_re1", re_q[1], 7'h04);
        check("late_ld", ld_q[0], 8'h5E);
        check("late_err1", n_err, 1);

        check("overlap", n_ovl, 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
